// File: rtl/shifter_pipe.sv
// Pipelined log shifter: rotates, logical and arithmetic shifts.
// Shift levels are spread across NUM_STAGES registered stages with valid/ready flow.
module shifter_pipe #(
  parameter int WIDTH      = 16,
  parameter int CNT_W      = 4,
  parameter int NUM_STAGES = 2,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PER  = CNT_W / NUM_STAGES;
  localparam int LAST = NUM_STAGES - 1;

  logic                  adv;
  logic [NUM_STAGES-1:0] vq;
  logic [WIDTH-1:0]      dq [NUM_STAGES];
  logic [CNT_W-1:0]      cq [NUM_STAGES];
  logic [2:0]            oq [NUM_STAGES];
  logic [TAG_W-1:0]      tq [NUM_STAGES];
  logic [WIDTH-1:0]      sh [NUM_STAGES];
  logic                  zero_r;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  function automatic logic [WIDTH-1:0] lvl(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       op,
    input int               s
  );
    logic [WIDTH-1:0] r;
    r = d;
    case (op)
      3'b000:  r = (d << s) | (d >> (WIDTH - s));
      3'b001:  r = d << s;
      3'b010:  r = (d >> s) | (d << (WIDTH - s));
      3'b011:  r = d >> s;
      3'b100:  r = $unsigned($signed(d) >>> s);
      default: r = d;
    endcase
    return r;
  endfunction

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_st
    localparam int LO = k * PER;
    localparam int HI = (k == LAST) ? CNT_W : (k + 1) * PER;

    logic             iv;
    logic [WIDTH-1:0] id;
    logic [CNT_W-1:0] ic;
    logic [2:0]       io;
    logic [TAG_W-1:0] it;
    logic [WIDTH-1:0] x;

    logic             v_r;
    logic [WIDTH-1:0] d_r;
    logic [CNT_W-1:0] c_r;
    logic [2:0]       o_r;
    logic [TAG_W-1:0] t_r;

    if (k == 0) begin : g_in
      assign iv = in_valid;
      assign id = in_data;
      assign ic = in_cnt;
      assign io = in_op;
      assign it = in_tag;
    end else begin : g_mid
      assign iv = vq[k-1];
      assign id = dq[k-1];
      assign ic = cq[k-1];
      assign io = oq[k-1];
      assign it = tq[k-1];
    end

    always_comb begin
      x = id;
      for (int l = LO; l < HI; l++) begin
        if (ic[l]) x = lvl(x, io, 1 << l);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_r <= 1'b0;
        d_r <= '0;
        c_r <= '0;
        o_r <= '0;
        t_r <= '0;
      end else if (flush) begin
        v_r <= 1'b0;
      end else if (adv) begin
        v_r <= iv;
        d_r <= x;
        c_r <= ic;
        o_r <= io;
        t_r <= it;
      end
    end

    assign vq[k] = v_r;
    assign dq[k] = d_r;
    assign cq[k] = c_r;
    assign oq[k] = o_r;
    assign tq[k] = t_r;
    assign sh[k] = x;
  end

  // zero flag tracks the last stage's data register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_r <= 1'b0;
    end else if (!flush && adv) begin
      zero_r <= (sh[LAST] == '0);
    end
  end

  assign out_valid = vq[LAST];
  assign out_data  = dq[LAST];
  assign out_tag   = tq[LAST];
  assign out_err   = (oq[LAST] >= 3'd5);
  assign out_zero  = zero_r;

endmodule

// File: tb/tb_shifter_pipe.sv
// Bench for shifter_pipe: directed vectors, backpressure,
// flush/reset and a randomized scoreboard run.
module tb_shifter_pipe;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_cnt;
  logic [2:0]  in_op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_zero;
  logic        out_err;
  logic [3:0]  out_tag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shifter_pipe #(
    .WIDTH(16), .CNT_W(4), .NUM_STAGES(2), .TAG_W(4)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_cnt(in_cnt),
    .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero),
    .out_err(out_err), .out_tag(out_tag)
  );

  typedef struct {
    logic [15:0] d;
    logic [3:0]  c;
    logic [2:0]  op;
    logic [15:0] ed;
    logic        ez;
    logic        ee;
  } vec_t;

  vec_t vt [8];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // reference: {data, zero, err}
  function automatic logic [17:0] model(input logic [15:0] d,
                                        input logic [3:0] c,
                                        input logic [2:0] op);
    logic [31:0] t;
    logic [15:0] r;
    logic        e;
    e = 1'b0;
    t = 32'h0;
    case (op)
      3'd0: begin t = {d, d} << c; r = t[31:16]; end
      3'd1: r = d << c;
      3'd2: begin t = {d, d} >> c; r = t[15:0]; end
      3'd3: r = d >> c;
      3'd4: begin t = {{16{d[15]}}, d} >> c; r = t[15:0]; end
      default: begin r = d; e = 1'b1; end
    endcase
    return {r, (r == 16'h0), e};
  endfunction

  task automatic run_one(input vec_t v, input logic [3:0] tag,
                         input string nm);
    int lat;
    in_valid = 1'b1;
    in_data  = v.d;
    in_cnt   = v.c;
    in_op    = v.op;
    in_tag   = tag;
    #1;
    check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, lat, 32'd2);
    check({nm, "_data"}, 32'(out_data), 32'(v.ed));
    check({nm, "_flags"}, {30'd0, out_zero, out_err}, {30'd0, v.ez, v.ee});
    check({nm, "_tag"}, 32'(out_tag), 32'(tag));
    @(posedge clk); #1;
  endtask

  logic [21:0] q [$];

  initial begin
    vt[0] = '{16'h8001, 4'd1,  3'd0, 16'h0003, 1'b0, 1'b0};
    vt[1] = '{16'h8001, 4'd1,  3'd1, 16'h0002, 1'b0, 1'b0};
    vt[2] = '{16'h0001, 4'd4,  3'd2, 16'h1000, 1'b0, 1'b0};
    vt[3] = '{16'h8000, 4'd15, 3'd3, 16'h0001, 1'b0, 1'b0};
    vt[4] = '{16'h8000, 4'd15, 3'd4, 16'hFFFF, 1'b0, 1'b0};
    vt[5] = '{16'h4000, 4'd14, 3'd4, 16'h0001, 1'b0, 1'b0};
    vt[6] = '{16'h8000, 4'd1,  3'd1, 16'h0000, 1'b1, 1'b0};
    vt[7] = '{16'h1234, 4'd3,  3'd6, 16'h1234, 1'b0, 1'b1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; in_cnt = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b1;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_zero", 32'(out_zero), 32'd0);
    check("rst_err", 32'(out_err), 32'd0);
    check("rst_tag", 32'(out_tag), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_one(vt[i], 4'(i + 1), $sformatf("vec%0d", i));
    end

    // backpressure: tags 1..4, consumer stalls from cycle 2 to 8
    begin
      int next;
      int got [$];
      next = 1;
      for (int cyc = 0; cyc < 30; cyc++) begin
        in_valid  = (next <= 4);
        in_tag    = 4'(next);
        in_data   = 16'(next);
        in_cnt    = 4'd0;
        in_op     = 3'd1;
        out_ready = (cyc < 2 || cyc >= 8);
        #1;
        if (out_valid && !out_ready) begin
          check("bp_in_ready", 32'(in_ready), 32'd0);
          check("bp_hold_tag", 32'(out_tag), 32'd1);
          check("bp_hold_data", 32'(out_data), 32'd1);
        end
        if (in_valid && in_ready) next++;
        if (out_valid && out_ready) got.push_back(int'(out_tag));
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("bp_count", got.size(), 32'd4);
      for (int i = 0; i < got.size(); i++) begin
        check($sformatf("bp_order%0d", i), got[i], i + 1);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;

    // flush with ops in flight
    in_valid = 1'b1; in_data = 16'h00F0; in_cnt = 4'd1;
    in_op = 3'd1; in_tag = 4'd7;
    @(posedge clk); #1;
    in_tag = 4'd8; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("flush_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    run_one(vt[0], 4'd9, "post_flush");

    // reset while stalled
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h1234; in_cnt = 4'd2;
    in_op = 3'd7; in_tag = 4'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_err", 32'(out_err), 32'd1);
    rst = 1'b1;
    #1;
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_data", 32'(out_data), 32'd0);
    check("mrst_flags", {30'd0, out_zero, out_err}, 32'd0);
    check("mrst_tag", 32'(out_tag), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // randomized run against the reference model
    begin
      int pushed;
      int cycles;
      logic [21:0] e;
      pushed = 0;
      cycles = 0;
      while (pushed < 10000 && cycles < 60000) begin
        in_valid  = 1'($urandom_range(0, 1));
        in_data   = 16'($urandom);
        in_cnt    = 4'($urandom_range(0, 15));
        in_op     = 3'($urandom_range(0, 7));
        in_tag    = 4'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (in_valid && in_ready) begin
          q.push_back({model(in_data, in_cnt, in_op), in_tag});
          pushed++;
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            check("rnd_spurious", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            check("rnd_result",
                  32'({out_data, out_zero, out_err, out_tag}), 32'(e));
          end
        end
        @(posedge clk); #1;
        cycles++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
        if (out_valid) begin
          if (q.size() == 0) begin
            check("rnd_spurious", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            check("rnd_drain",
                  32'({out_data, out_zero, out_err, out_tag}), 32'(e));
          end
        end
        @(posedge clk); #1;
      end
      check("rnd_pushed", pushed, 32'd10000);
      check("rnd_left", q.size(), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
